id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage of the five-stage MIPS pipeline; sits between the IF/ID register and the EX stage.
- Drives the register-file read addresses and consumes the read data the same cycle.
- Bypasses in-flight results from MEM and WB, detects load-use hazards, and holds the registered ID/EX pipeline outputs under a valid/ready handshake.

Parameters:
DW, 32, datapath width
AW, 5, register address width (32 GPRs)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
if_valid  in  1  IF/ID holds a valid instruction
if_instr  in  DW  instruction word
if_pc  in  DW  instruction PC
id_ready  out  1  ID accepts the IF/ID word this cycle
flush  in  1  branch/exception flush from EX
rf_rs  out  AW  register file read address 1 (= if_instr[25:21])
rf_rt  out  AW  register file read address 2 (= if_instr[20:16])
rf_rs_data  in  DW  register file read data 1 (combinational)
rf_rt_data  in  DW  register file read data 2
ex_is_load  in  1  instruction now in EX is a load
ex_wr_addr  in  AW  EX destination register
mem_wr_en  in  1  MEM stage will write a GPR
mem_wr_addr  in  AW  MEM destination
mem_wr_data  in  DW  MEM result
wb_wr_en  in  1  WB writes the register file this cycle
wb_wr_addr  in  AW  WB destination
wb_wr_data  in  DW  WB data
ex_ready  in  1  EX accepts ID/EX contents
idex_valid  out  1  ID/EX register valid
idex_pc  out  DW  registered PC
idex_rs_val  out  DW  forwarded rs operand
idex_rt_val  out  DW  forwarded rt operand
idex_imm  out  DW  extended immediate
idex_dst  out  AW  destination register
idex_opcode  out  6  instr[31:26]
idex_funct  out  6  instr[5:0]
idex_shamt  out  5  instr[10:6]

Behaviour:
- Reset:
  - One clock, clk.
  - Asynchronous active-low reset rstn; assertion immediately clears all idex_* outputs to 0, including idex_valid=0.
  - id_ready is combinational and depends only on live inputs.
- Reset mid-operation:
  - Any in-flight ID/EX word is discarded; no partial state survives.
- Hazard:
  - hazard = if_valid & ex_is_load & ex_wr_addr!=0 & (ex_wr_addr==rf_rs | ex_wr_addr==rf_rt).
- Handshake:
  - id_ready = flush | (!hazard & (ex_ready | !idex_valid)).
  - Transfer = if_valid & id_ready & !flush.
- Register update priority, per posedge:
  1. flush: idex_valid<=0 (both the ID/EX word and the IF/ID word are dropped).
  2. Transfer: all idex_* loaded, idex_valid<=1.
  3. hazard & ex_ready: bubble, idex_valid<=0; other fields don't-care but held.
  4. ex_ready | !idex_valid, with no transfer: idex_valid<=0.
  5. Otherwise: hold all outputs.
- Latency: one cycle from accepted IF/ID word to idex_valid.
- Load-use penalty: exactly one bubble; when the load advances, ex_is_load deasserts and the dependent word is accepted with the value forwarded from MEM.
- Forwarding, per operand, evaluated combinationally before the ID/EX register:
  - addr==0 gives 0.
  - Else mem_wr_en & mem_wr_addr==addr gives mem_wr_data.
  - Else wb_wr_en & wb_wr_addr==addr gives wb_wr_data; the register file returns the old value during its write cycle.
  - Else rf data.
  - MEM has priority over WB when both match.
- Destination:
  - opcode 000000 gives instr[15:11].
  - opcode 000011 (jal) gives 31.
  - Stores (101xxx), branches (0001xx, 000001) and j (000010) give 0.
  - All other opcodes give instr[20:16].
- Immediate:
  - andi/ori/xori (0x0C/0x0D/0x0E) zero-extend instr[15:0].
  - All other opcodes sign-extend.
- Simultaneous flush & hazard: flush wins; id_ready=1 so IF/ID drains.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_ANDI, OP_ORI, OP_XORI, load/store groups)
  - AW/DW
  - REG_ZERO=0, REG_RA=31
- Sub-module fwd_mux: one per operand, inputs addr, rf data, MEM and WB triples, output operand. Shared with a future EX-stage bypass.

Test Plan:
- Reset, idle:
  - Stimulus: rstn low, if_valid=1.
  - Required: idex_valid=0, all idex_*=0; one cycle after release with ex_ready=1, idex_valid=1.
- R-type decode:
  - Stimulus: addu $3,$1,$2 (0x00221821), rf data 5 and 7, no fwd.
  - Required: next cycle idex_rs_val=5, idex_rt_val=7, idex_dst=3, idex_funct=0x21.
- Forward priority:
  - Stimulus: rs=$4; MEM writes $4=0xAAAA and WB writes $4=0xBBBB, rf=0x1111.
  - Required: idex_rs_val=0xAAAA. With MEM off: 0xBBBB. With rs=$0 and all matching: 0.
- Load-use:
  - Stimulus: ex_is_load=1, ex_wr_addr=2, instruction uses rt=$2.
  - Required: id_ready=0, idex_valid=0 for one cycle; next cycle accepted with MEM data forwarded.
- Backpressure:
  - Stimulus: idex_valid=1, ex_ready=0 for 3 cycles.
  - Required: id_ready=0 and all idex_* stable; accepted the cycle ex_ready rises.
- Flush vs. hazard:
  - Stimulus: flush=1 together with hazard and ex_ready=0.
  - Required: id_ready=1, next cycle idex_valid=0.
- Immediate extension:
  - Stimulus: ori with imm 0x8000.
  - Required: idex_imm=0x00008000; addiu with the same imm gives 0xFFFF8000.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode constants, register widths and decode helpers for the MIPS pipeline
package mips_pkg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [3:0] OP_BRANCH_GRP = 4'b0001;
  localparam logic [2:0] OP_LOAD_GRP = 3'b100;
  localparam logic [2:0] OP_STORE_GRP = 3'b101;
  localparam logic [AW-1:0] REG_ZERO = '0;
  localparam logic [AW-1:0] REG_RA = 5'd31;

  function automatic logic [AW-1:0] dest_reg(input logic [5:0] op, input logic [AW-1:0] rt, input logic [AW-1:0] rd);
    return op == OP_RTYPE ? rd :
           op == OP_JAL ? REG_RA :
           (op[5:3] == OP_STORE_GRP || op[5:2] == OP_BRANCH_GRP || op == OP_REGIMM || op == OP_J) ? REG_ZERO :
           rt;
  endfunction

  function automatic logic zero_ext_imm(input logic [5:0] op);
    return op == OP_ANDI || op == OP_ORI || op == OP_XORI;
  endfunction
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: operand bypass selecting MEM, then WB, then register-file data; $0 always reads zero
module fwd_mux #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] rf_data,
  input  logic          mem_wr_en,
  input  logic [AW-1:0] mem_wr_addr,
  input  logic [DW-1:0] mem_wr_data,
  input  logic          wb_wr_en,
  input  logic [AW-1:0] wb_wr_addr,
  input  logic [DW-1:0] wb_wr_data,
  output logic [DW-1:0] operand
);
  // youngest in-flight result wins; the register file still returns the old value during its write
  always_comb
    operand = addr == '0 ? '0 :
              (mem_wr_en && mem_wr_addr == addr) ? mem_wr_data :
              (wb_wr_en && wb_wr_addr == addr) ? wb_wr_data :
              rf_data;
endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS decode stage with operand bypass, load-use stall and ID/EX handshake register
module id_stage #(
  parameter int DW = mips_pkg::DW,
  parameter int AW = mips_pkg::AW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          if_valid,
  input  logic [DW-1:0] if_instr,
  input  logic [DW-1:0] if_pc,
  output logic          id_ready,
  input  logic          flush,
  output logic [AW-1:0] rf_rs,
  output logic [AW-1:0] rf_rt,
  input  logic [DW-1:0] rf_rs_data,
  input  logic [DW-1:0] rf_rt_data,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_wr_addr,
  input  logic          mem_wr_en,
  input  logic [AW-1:0] mem_wr_addr,
  input  logic [DW-1:0] mem_wr_data,
  input  logic          wb_wr_en,
  input  logic [AW-1:0] wb_wr_addr,
  input  logic [DW-1:0] wb_wr_data,
  input  logic          ex_ready,
  output logic          idex_valid,
  output logic [DW-1:0] idex_pc,
  output logic [DW-1:0] idex_rs_val,
  output logic [DW-1:0] idex_rt_val,
  output logic [DW-1:0] idex_imm,
  output logic [AW-1:0] idex_dst,
  output logic [5:0]    idex_opcode,
  output logic [5:0]    idex_funct,
  output logic [4:0]    idex_shamt
);
  import mips_pkg::*;
  logic [5:0] opcode;
  logic [DW-1:0] rs_val, rt_val, imm;
  logic [AW-1:0] dst;
  logic hazard, xfer;

  // field split, load-use detection and handshake; flush forces ready so IF/ID drains
  always_comb begin
    opcode = if_instr[31:26];
    rf_rs = if_instr[25:21];
    rf_rt = if_instr[20:16];
    hazard = if_valid & ex_is_load & (ex_wr_addr != '0) & (ex_wr_addr == rf_rs | ex_wr_addr == rf_rt);
    id_ready = flush | (!hazard & (ex_ready | !idex_valid));
    xfer = if_valid & id_ready & !flush;
    dst = dest_reg(opcode, if_instr[20:16], if_instr[15:11]);
    imm = {{(DW-16){~zero_ext_imm(opcode) & if_instr[15]}}, if_instr[15:0]};
  end

  fwd_mux #(.DW(DW), .AW(AW)) rs_fwd (
    .addr(rf_rs), .rf_data(rf_rs_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .operand(rs_val)
  );

  fwd_mux #(.DW(DW), .AW(AW)) rt_fwd (
    .addr(rf_rt), .rf_data(rf_rt_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .operand(rt_val)
  );

  // ID/EX register: flush drops, transfer loads, a consumed or empty slot empties, else hold
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      idex_valid <= 1'b0;
      idex_pc <= '0;
      idex_rs_val <= '0;
      idex_rt_val <= '0;
      idex_imm <= '0;
      idex_dst <= '0;
      idex_opcode <= '0;
      idex_funct <= '0;
      idex_shamt <= '0;
    end else if (flush)
      idex_valid <= 1'b0;
    else if (xfer) begin
      idex_valid <= 1'b1;
      idex_pc <= if_pc;
      idex_rs_val <= rs_val;
      idex_rt_val <= rt_val;
      idex_imm <= imm;
      idex_dst <= dst;
      idex_opcode <= opcode;
      idex_funct <= if_instr[5:0];
      idex_shamt <= if_instr[10:6];
    end else if (ex_ready | !idex_valid)
      idex_valid <= 1'b0;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for the decode stage
module tb_id_stage;
  logic clk = 1'b0, rstn = 1'b0;
  logic if_valid = 1'b0, flush = 1'b0, ex_is_load = 1'b0, ex_ready = 1'b0;
  logic mem_wr_en = 1'b0, wb_wr_en = 1'b0;
  logic [31:0] if_instr = '0, if_pc = '0, rf_rs_data = '0, rf_rt_data = '0, mem_wr_data = '0, wb_wr_data = '0;
  logic [4:0] ex_wr_addr = '0, mem_wr_addr = '0, wb_wr_addr = '0;
  logic id_ready, idex_valid;
  logic [4:0] rf_rs, rf_rt, idex_dst, idex_shamt;
  logic [31:0] idex_pc, idex_rs_val, idex_rt_val, idex_imm;
  logic [5:0] idex_opcode, idex_funct;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rstn(rstn), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .rf_rs(rf_rs), .rf_rt(rf_rt),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data), .ex_ready(ex_ready),
    .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_rs_val(idex_rs_val), .idex_rt_val(idex_rt_val),
    .idex_imm(idex_imm), .idex_dst(idex_dst), .idex_opcode(idex_opcode), .idex_funct(idex_funct),
    .idex_shamt(idex_shamt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if_valid = 1'b1; if_instr = 32'h00221821; if_pc = 32'h40; ex_ready = 1'b1;
    rf_rs_data = 32'd5; rf_rt_data = 32'd7;
    step(); step();
    tests++; if (idex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", idex_valid); end
    tests++;
    if ({idex_pc, idex_rs_val, idex_rt_val, idex_imm, idex_dst, idex_opcode, idex_funct, idex_shamt} !== '0) begin
      fails++; $display("FAIL reset_fields pc=%h rs=%h rt=%h imm=%h dst=%0d want all 0", idex_pc, idex_rs_val, idex_rt_val, idex_imm, idex_dst);
    end
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b want 1", id_ready); end
    rstn = 1'b1;
    step();
    tests++; if (idex_valid !== 1'b1) begin fails++; $display("FAIL post_reset_valid got %0b want 1", idex_valid); end
  endtask

  task automatic test_rtype();
    if_instr = 32'h00221821; if_pc = 32'h44; rf_rs_data = 32'd5; rf_rt_data = 32'd7;
    #1;
    tests++; if (rf_rs !== 5'd1 || rf_rt !== 5'd2) begin fails++; $display("FAIL rf_addr got %0d/%0d want 1/2", rf_rs, rf_rt); end
    step();
    tests++; if (idex_rs_val !== 32'd5 || idex_rt_val !== 32'd7) begin fails++; $display("FAIL rtype_ops got %0d/%0d want 5/7", idex_rs_val, idex_rt_val); end
    tests++; if (idex_dst !== 5'd3 || idex_funct !== 6'h21 || idex_opcode !== 6'h00) begin fails++; $display("FAIL rtype_fields dst=%0d funct=%h op=%h want 3/21/00", idex_dst, idex_funct, idex_opcode); end
    tests++; if (idex_pc !== 32'h44 || idex_valid !== 1'b1) begin fails++; $display("FAIL rtype_pc pc=%h v=%0b want 44/1", idex_pc, idex_valid); end
  endtask

  task automatic test_forward();
    if_instr = 32'h00802821; rf_rs_data = 32'h1111; rf_rt_data = 32'h2222;
    mem_wr_en = 1'b1; mem_wr_addr = 5'd4; mem_wr_data = 32'hAAAA;
    wb_wr_en = 1'b1; wb_wr_addr = 5'd4; wb_wr_data = 32'hBBBB;
    step();
    tests++; if (idex_rs_val !== 32'hAAAA) begin fails++; $display("FAIL fwd_mem got %h want aaaa", idex_rs_val); end
    tests++; if (idex_rt_val !== 32'h0) begin fails++; $display("FAIL fwd_rt_zero got %h want 0", idex_rt_val); end
    mem_wr_en = 1'b0;
    step();
    tests++; if (idex_rs_val !== 32'hBBBB) begin fails++; $display("FAIL fwd_wb got %h want bbbb", idex_rs_val); end
    wb_wr_addr = 5'd6;
    step();
    tests++; if (idex_rs_val !== 32'h1111) begin fails++; $display("FAIL fwd_rf got %h want 1111", idex_rs_val); end
    if_instr = 32'h00002821; mem_wr_en = 1'b1; mem_wr_addr = 5'd0; wb_wr_addr = 5'd0; rf_rs_data = 32'h1111;
    step();
    tests++; if (idex_rs_val !== 32'h0) begin fails++; $display("FAIL fwd_r0 got %h want 0", idex_rs_val); end
    mem_wr_en = 1'b0; wb_wr_en = 1'b0;
  endtask

  task automatic test_load_use();
    if_instr = 32'h00221821; if_pc = 32'h100; rf_rs_data = 32'd9; rf_rt_data = 32'd1;
    ex_is_load = 1'b1; ex_wr_addr = 5'd0;
    #1;
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL lu_r0_ready got %0b want 1", id_ready); end
    ex_wr_addr = 5'd2;
    #1;
    tests++; if (id_ready !== 1'b0) begin fails++; $display("FAIL lu_ready got %0b want 0", id_ready); end
    step();
    tests++; if (idex_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble got %0b want 0", idex_valid); end
    ex_is_load = 1'b0; mem_wr_en = 1'b1; mem_wr_addr = 5'd2; mem_wr_data = 32'hDEAD;
    #1;
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL lu_release got %0b want 1", id_ready); end
    step();
    tests++; if (idex_valid !== 1'b1 || idex_rt_val !== 32'hDEAD || idex_rs_val !== 32'd9 || idex_pc !== 32'h100) begin
      fails++; $display("FAIL lu_accept v=%0b rt=%h rs=%h pc=%h want 1/dead/9/100", idex_valid, idex_rt_val, idex_rs_val, idex_pc);
    end
    mem_wr_en = 1'b0;
  endtask

  task automatic test_backpressure();
    ex_ready = 1'b0; if_instr = 32'h2427FFFF; if_pc = 32'h104;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (id_ready !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d] got %0b want 0", i, id_ready); end
      step();
      tests++; if (idex_valid !== 1'b1 || idex_pc !== 32'h100 || idex_rt_val !== 32'hDEAD || idex_dst !== 5'd3) begin
        fails++; $display("FAIL bp_hold[%0d] v=%0b pc=%h rt=%h dst=%0d want 1/100/dead/3", i, idex_valid, idex_pc, idex_rt_val, idex_dst);
      end
    end
    ex_ready = 1'b1;
    #1;
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL bp_release got %0b want 1", id_ready); end
    step();
    tests++; if (idex_pc !== 32'h104 || idex_dst !== 5'd7 || idex_imm !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL bp_accept pc=%h dst=%0d imm=%h want 104/7/ffffffff", idex_pc, idex_dst, idex_imm);
    end
  endtask

  task automatic test_flush_hazard();
    ex_ready = 1'b0; ex_is_load = 1'b1; ex_wr_addr = 5'd1; if_instr = 32'h00221821; flush = 1'b1;
    #1;
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL flush_ready got %0b want 1", id_ready); end
    step();
    tests++; if (idex_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %0b want 0", idex_valid); end
    flush = 1'b0; ex_is_load = 1'b0; ex_ready = 1'b1;
  endtask

  task automatic test_imm_dst();
    logic [31:0] instr [6] = '{32'h34228000, 32'h24228000, 32'hAC228000, 32'h0C000010, 32'h10220004, 32'h8C220004};
    logic [31:0] eimm [6] = '{32'h00008000, 32'hFFFF8000, 32'hFFFF8000, 32'h00000010, 32'h00000004, 32'h00000004};
    logic [4:0] edst [6] = '{5'd2, 5'd2, 5'd0, 5'd31, 5'd0, 5'd2};
    for (int i = 0; i < 6; i++) begin
      if_instr = instr[i];
      step();
      tests++; if (idex_imm !== eimm[i] || idex_dst !== edst[i]) begin
        fails++; $display("FAIL imm_dst[%0d] imm=%h dst=%0d want %h/%0d", i, idex_imm, idex_dst, eimm[i], edst[i]);
      end
    end
  endtask

  task automatic test_idle_and_reset();
    if_valid = 1'b0;
    step();
    tests++; if (idex_valid !== 1'b0) begin fails++; $display("FAIL idle_valid got %0b want 0", idex_valid); end
    if_valid = 1'b1; if_pc = 32'h200;
    step();
    #2 rstn = 1'b0;
    #1;
    tests++; if (idex_valid !== 1'b0 || idex_pc !== 32'h0 || idex_imm !== 32'h0) begin
      fails++; $display("FAIL async_reset v=%0b pc=%h imm=%h want 0/0/0", idex_valid, idex_pc, idex_imm);
    end
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_forward();
    test_load_use();
    test_backpressure();
    test_flush_hazard();
    test_imm_dst();
    test_idle_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
